param_tiny_processor: RTL and testbench
=======================================

// Module: param_tiny_processor
// PURPOSE
//  Parametrised multi-cycle accumulator processor (A/B regs, carry + zero flags, GPIO).
//  DATA_W-bit datapath, 2^ADDR_W-word program RAM loadable at run time, explicit HALT state.
//  New vs. previous gen: HLT and JNZ opcodes, NOP slots, start/stop control, status outputs.
//  Sits between board GPIO (switches/LEDs) and a host/UART loader that writes programs.
// PARAMETERS
//  DATA_W  4  width of A, B, immediate, gpio_in/out; range 4..16
//  ADDR_W  4  PC width; program depth 2^ADDR_W; constraint ADDR_W <= DATA_W
// PORTS
//  clock      in   1             system clock, all state on rising edge
//  reset_p    in   1             synchronous, active-high reset
//  start      in   1             pulse: leave HALT, begin fetch at current PC
//  stop       in   1             pulse/level: halt at next instruction boundary
//  prog_we    in   1             program RAM write enable (honoured only in HALT)
//  prog_addr  in   ADDR_W        program RAM write address
//  prog_data  in   4+DATA_W      {opcode[3:0], imm[DATA_W-1:0]}
//  gpio_in    in   DATA_W        input port, sampled in SELECT
//  gpio_out   out  DATA_W        output port register
//  halted     out  1             1 while FSM is in HALT
//  pc_out     out  ADDR_W        current PC
//  flags_out  out  2             {ZF, CF}
// BEHAVIOUR
//  Reset (one clock): state=HALT; PC, A, B, CF, ZF, gpio_out, pipeline regs = 0.
//   Program RAM is NOT reset; contents persist across reset_p.
//  FSM: HALT -> FETCH -> DECODE -> SELECT -> EXEC -> WB -> FETCH; 5 clocks/instruction.
//   HALT: start=1 & stop=0 -> FETCH; otherwise stay. start & stop together -> stay in HALT.
//   WB: stop=1 (sampled at the WB edge) or opcode HLT -> HALT, else -> FETCH.
//   stop outside WB is latched (stop_pend); cleared on HALT entry. The instruction always completes.
//  FETCH: {INST, IMM} <= mem[PC] (async read, registered).
//  SELECT: sel_val <= A | B | gpio_in | 0.
//  EXEC: {CF, res} <= sel_val + IMM, (DATA_W+1)-bit sum. ZF <= (res == 0).
//   Flags update on every executed opcode, including jumps, OUT and NOP.
//  WB: write res to A/B/gpio_out per decode. PC <= jump ? res[ADDR_W-1:0] : PC+1, wrapping mod 2^ADDR_W.
//  Opcodes (dest <= src + IMM):
//   0 A<=0+I   1 B<=0+I   2 A<=B+I   3 B<=A+I   4 A<=A+I   5 B<=B+I
//   6 A<=IN+I  7 B<=IN+I  8 OUT<=0+I  9 OUT<=B+I
//   A JMP I    B JNC I (jump iff CF=0)  C HLT (PC+1, then HALT)
//   D JNZ I (jump iff ZF=0)  E,F NOP (PC+1 only)
//  Jump and HLT conditions use the flags as they were before this instruction's EXEC.
//   Decode samples CF/ZF in DECODE.
//  prog_we: in HALT, mem[prog_addr] <= prog_data at the edge. In any other state it is ignored.
//   prog_we with start in the same cycle: the write lands; the FETCH that follows reads the new word.
//  pc_out, flags_out, gpio_out, halted are direct register outputs (no combinational paths).
// STRUCTURE
//  Shared package tp_pkg: opcode constants (OP_MOVA..OP_NOP), FSM state encoding,
//   decode control word {wr_en[2:0], jump, halt, sel[1:0]}.
//  Sub-module tp_prog_mem: 2^ADDR_W x (4+DATA_W) register file, sync write, async read.
//  Decode stays an in-module function/case.
// TESTING
//  1 Load mem0=0x85, mem1=0xC0; start -> gpio_out=5 after 5th clk post-start;
//    halted=1 after 10th clk; pc_out=2.
//  2 Carry loop: 0:0x0E, 1:0x41, 2:0xB1, 3:0x8F, 4:0xC0
//    -> A wraps 0xF->0 with CF=1, falls through, gpio_out=0xF, halts at pc_out=5.
//  3 JNZ countdown DATA_W=8: A<=3; loop A<=A+0xFF; JNZ loop; OUT 0xAA; HLT
//    -> gpio_out=0xAA, A=0; loop body executed exactly 3 times.
//  4 stop pulse during DECODE of instr k -> instr k writes back, halted=1, pc_out=k+1;
//    start resumes at k+1.
//  5 prog_we while running -> mem unchanged (read back via re-run);
//    reset_p mid-EXEC -> all outputs 0, halted=1, program reruns identically on start.
//  6 gpio_in=0x9, program 0:0x61, 1:0x92?? n/a -> use 0:0x71, 1:0x90
//    -> B=0xA, gpio_out=0xA; start+stop same cycle in HALT -> stays halted.

Source files
------------

// File: rtl/tp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tp_pkg
// Description : Shared opcodes, FSM state encoding and decode control word
//               for the parametrised tiny accumulator processor.
// Revision    : 1.0 - initial release
// ============================================================================
package tp_pkg;

   // Opcodes: dest <= src + IMM unless noted
   localparam logic [3:0] OP_MOVA  = 4'h0;  // A   <= 0 + I
   localparam logic [3:0] OP_MOVB  = 4'h1;  // B   <= 0 + I
   localparam logic [3:0] OP_MOVAB = 4'h2;  // A   <= B + I
   localparam logic [3:0] OP_MOVBA = 4'h3;  // B   <= A + I
   localparam logic [3:0] OP_ADDA  = 4'h4;  // A   <= A + I
   localparam logic [3:0] OP_ADDB  = 4'h5;  // B   <= B + I
   localparam logic [3:0] OP_INA   = 4'h6;  // A   <= IN + I
   localparam logic [3:0] OP_INB   = 4'h7;  // B   <= IN + I
   localparam logic [3:0] OP_OUTI  = 4'h8;  // OUT <= 0 + I
   localparam logic [3:0] OP_OUTB  = 4'h9;  // OUT <= B + I
   localparam logic [3:0] OP_JMP   = 4'hA;
   localparam logic [3:0] OP_JNC   = 4'hB;
   localparam logic [3:0] OP_HLT   = 4'hC;
   localparam logic [3:0] OP_JNZ   = 4'hD;
   localparam logic [3:0] OP_NOP   = 4'hE;  // 4'hF decodes as NOP too

   typedef enum logic [2:0] {
      ST_HALT   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_SELECT = 3'd3,
      ST_EXEC   = 3'd4,
      ST_WB     = 3'd5
   } tp_state_t;

   // Operand source select
   localparam logic [1:0] SEL_ZERO = 2'd0;
   localparam logic [1:0] SEL_A    = 2'd1;
   localparam logic [1:0] SEL_B    = 2'd2;
   localparam logic [1:0] SEL_IN   = 2'd3;

   // Write-back enables {OUT, B, A}
   localparam logic [2:0] WR_NONE = 3'b000;
   localparam logic [2:0] WR_A    = 3'b001;
   localparam logic [2:0] WR_B    = 3'b010;
   localparam logic [2:0] WR_OUT  = 3'b100;

   typedef struct packed {
      logic [2:0] wr_en;
      logic       jump;
      logic       halt;
      logic [1:0] sel;
   } tp_ctrl_t;

endpackage
`default_nettype wire

// File: rtl/tp_prog_mem.sv
`default_nettype none
// ============================================================================
// Module      : tp_prog_mem
// Description : Program store, 2^ADDR_W words; synchronous write,
//               asynchronous read. Contents are deliberately not reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tp_prog_mem #(
   parameter int WORD_W = 8,
   parameter int ADDR_W = 4
) (
   input  logic              clock,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_wr_addr,
   input  logic [WORD_W-1:0] i_wr_data,
   input  logic [ADDR_W-1:0] i_rd_addr,
   output logic [WORD_W-1:0] o_rd_data
);

   localparam int c_DEPTH = 1 << ADDR_W;

   logic [WORD_W-1:0] r_mem [c_DEPTH];

   // Loader write port; gating against run state is done by the caller
   always_ff @(posedge clock) begin
      if (i_we) begin
         r_mem[i_wr_addr] <= i_wr_data;
      end
   end

   assign o_rd_data = r_mem[i_rd_addr];

endmodule
`default_nettype wire

// File: rtl/param_tiny_processor.sv
`default_nettype none
// ============================================================================
// Module      : param_tiny_processor
// Description : Multi-cycle accumulator processor (A/B, carry/zero flags,
//               GPIO) with run-time loadable program RAM and a HALT state.
//               Five clocks per instruction: FETCH DECODE SELECT EXEC WB.
// Revision    : 1.0 - initial release
// ============================================================================
module param_tiny_processor
   import tp_pkg::*;
#(
   parameter int DATA_W = 4,
   parameter int ADDR_W = 4
) (
   input  logic                clock,
   input  logic                reset_p,
   input  logic                start,
   input  logic                stop,
   input  logic                prog_we,
   input  logic [ADDR_W-1:0]   prog_addr,
   input  logic [DATA_W+3:0]   prog_data,
   input  logic [DATA_W-1:0]   gpio_in,
   output logic [DATA_W-1:0]   gpio_out,
   output logic                halted,
   output logic [ADDR_W-1:0]   pc_out,
   output logic [1:0]          flags_out
);

   localparam int                c_WORD_W = DATA_W + 4;
   localparam logic [ADDR_W-1:0] c_PC_ONE = ADDR_W'(1);

   tp_state_t         r_state;
   logic              r_halted;
   logic [ADDR_W-1:0] r_pc;
   logic [DATA_W-1:0] r_a;
   logic [DATA_W-1:0] r_b;
   logic [DATA_W-1:0] r_gpio_out;
   logic              r_cf;
   logic              r_zf;
   logic              r_stop_pend;
   logic [3:0]        r_op;
   logic [DATA_W-1:0] r_imm;
   tp_ctrl_t          r_ctrl;
   logic [DATA_W-1:0] r_sel_val;
   logic [DATA_W-1:0] r_res;

   logic [c_WORD_W-1:0] w_word;
   logic [DATA_W:0]     w_sum;
   logic                w_mem_we;
   logic                w_to_halt;

   // Loader writes only land while halted; reset takes priority
   assign w_mem_we  = prog_we && !reset_p && (r_state == ST_HALT);
   assign w_sum     = {1'b0, r_sel_val} + {1'b0, r_imm};
   assign w_to_halt = stop || r_stop_pend || r_ctrl.halt;

   tp_prog_mem #(
      .WORD_W (c_WORD_W),
      .ADDR_W (ADDR_W)
   ) u_prog_mem (
      .clock     (clock),
      .i_we      (w_mem_we),
      .i_wr_addr (prog_addr),
      .i_wr_data (prog_data),
      .i_rd_addr (r_pc),
      .o_rd_data (w_word)
   );

   // Jump/halt conditions are resolved here from the flags of the
   // previous instruction, before this instruction's EXEC updates them.
   function automatic tp_ctrl_t f_decode(input logic [3:0] op,
                                         input logic       cf,
                                         input logic       zf);
      tp_ctrl_t c;
      c = '{wr_en: WR_NONE, jump: 1'b0, halt: 1'b0, sel: SEL_ZERO};
      case (op)
         OP_MOVA:  c.wr_en = WR_A;
         OP_MOVB:  c.wr_en = WR_B;
         OP_MOVAB: begin c.wr_en = WR_A;   c.sel = SEL_B;  end
         OP_MOVBA: begin c.wr_en = WR_B;   c.sel = SEL_A;  end
         OP_ADDA:  begin c.wr_en = WR_A;   c.sel = SEL_A;  end
         OP_ADDB:  begin c.wr_en = WR_B;   c.sel = SEL_B;  end
         OP_INA:   begin c.wr_en = WR_A;   c.sel = SEL_IN; end
         OP_INB:   begin c.wr_en = WR_B;   c.sel = SEL_IN; end
         OP_OUTI:  c.wr_en = WR_OUT;
         OP_OUTB:  begin c.wr_en = WR_OUT; c.sel = SEL_B;  end
         OP_JMP:   c.jump  = 1'b1;
         OP_JNC:   c.jump  = !cf;
         OP_HLT:   c.halt  = 1'b1;
         OP_JNZ:   c.jump  = !zf;
         default:  ;
      endcase
      return c;
   endfunction

   // Sequencer and datapath: one instruction per FETCH..WB pass
   always_ff @(posedge clock) begin
      if (reset_p) begin
         r_state     <= ST_HALT;
         r_halted    <= 1'b1;
         r_pc        <= '0;
         r_a         <= '0;
         r_b         <= '0;
         r_gpio_out  <= '0;
         r_cf        <= 1'b0;
         r_zf        <= 1'b0;
         r_stop_pend <= 1'b0;
         r_op        <= '0;
         r_imm       <= '0;
         r_ctrl      <= '0;
         r_sel_val   <= '0;
         r_res       <= '0;
      end else begin
         case (r_state)
            ST_HALT: begin
               if (start && !stop) begin
                  r_state  <= ST_FETCH;
                  r_halted <= 1'b0;
               end
            end
            ST_FETCH: begin
               r_op    <= w_word[c_WORD_W-1:DATA_W];
               r_imm   <= w_word[DATA_W-1:0];
               r_state <= ST_DECODE;
            end
            ST_DECODE: begin
               r_ctrl  <= f_decode(r_op, r_cf, r_zf);
               r_state <= ST_SELECT;
            end
            ST_SELECT: begin
               case (r_ctrl.sel)
                  SEL_A:   r_sel_val <= r_a;
                  SEL_B:   r_sel_val <= r_b;
                  SEL_IN:  r_sel_val <= gpio_in;
                  default: r_sel_val <= '0;
               endcase
               r_state <= ST_EXEC;
            end
            ST_EXEC: begin
               r_cf    <= w_sum[DATA_W];
               r_res   <= w_sum[DATA_W-1:0];
               r_zf    <= (w_sum[DATA_W-1:0] == '0);
               r_state <= ST_WB;
            end
            ST_WB: begin
               if (r_ctrl.wr_en[0]) r_a        <= r_res;
               if (r_ctrl.wr_en[1]) r_b        <= r_res;
               if (r_ctrl.wr_en[2]) r_gpio_out <= r_res;
               r_pc     <= r_ctrl.jump ? r_res[ADDR_W-1:0] : r_pc + c_PC_ONE;
               r_state  <= w_to_halt ? ST_HALT : ST_FETCH;
               r_halted <= w_to_halt;
            end
            default: begin
               r_state  <= ST_HALT;
               r_halted <= 1'b1;
            end
         endcase

         // A stop seen mid-instruction is remembered until the WB boundary
         if (r_state == ST_WB) begin
            r_stop_pend <= 1'b0;
         end else if (r_state != ST_HALT && stop) begin
            r_stop_pend <= 1'b1;
         end
      end
   end

   assign gpio_out  = r_gpio_out;
   assign halted    = r_halted;
   assign pc_out    = r_pc;
   assign flags_out = {r_zf, r_cf};

endmodule
`default_nettype wire

// File: tb/tb_param_tiny_processor.sv
`default_nettype none
// ============================================================================
// Module      : tb_param_tiny_processor
// Description : Bench for param_tiny_processor: a 4-bit and an 8-bit instance
//               share control inputs; an instruction-level model is checked
//               against both every cycle, plus directed program scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_param_tiny_processor;

   logic        clock = 1'b0;
   logic        reset_p, start, stop, prog_we;
   logic [3:0]  prog_addr;
   logic [7:0]  prog_data0;
   logic [11:0] prog_data1;
   logic [3:0]  gpio_in0;
   logic [7:0]  gpio_in1;
   logic [3:0]  gpio_out0;
   logic [7:0]  gpio_out1;
   logic        halted0, halted1;
   logic [3:0]  pc_out0, pc_out1;
   logic [1:0]  flags0, flags1;

   int n_checks = 0;
   int n_errors = 0;
   bit chk_en   = 1'b0;

   always #5 clock = ~clock;

   param_tiny_processor #(.DATA_W(4), .ADDR_W(4)) u_dut4 (
      .clock(clock), .reset_p(reset_p), .start(start), .stop(stop),
      .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data0),
      .gpio_in(gpio_in0), .gpio_out(gpio_out0), .halted(halted0),
      .pc_out(pc_out0), .flags_out(flags0));

   param_tiny_processor #(.DATA_W(8), .ADDR_W(4)) u_dut8 (
      .clock(clock), .reset_p(reset_p), .start(start), .stop(stop),
      .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data1),
      .gpio_in(gpio_in1), .gpio_out(gpio_out1), .halted(halted1),
      .pc_out(pc_out1), .flags_out(flags1));

   // ---------------- instruction-level reference model ----------------
   int m_w [2] = '{4, 8};
   int m_mem [2][16];
   bit m_run [2];
   int m_cyc [2];              // clocks elapsed in current instruction
   int m_pc [2], m_a [2], m_b [2], m_out [2], m_res [2], m_word [2], m_in [2];
   bit m_cf [2], m_zf [2], m_pend [2], m_ocf [2], m_ozf [2];

   task automatic model_step(input int d, input bit rst, input bit st, input bit sp,
                             input bit we, input int addr, input int data, input int gin);
      int mask, op, imm, src, sum;
      bit taken;
      mask = (1 << m_w[d]) - 1;
      if (rst) begin
         m_run[d] = 0; m_cyc[d] = 0; m_pend[d] = 0;
         m_pc[d] = 0; m_a[d] = 0; m_b[d] = 0; m_out[d] = 0; m_res[d] = 0;
         m_cf[d] = 0; m_zf[d] = 0;
         return;
      end
      if (!m_run[d]) begin
         if (we) m_mem[d][addr] = data;
         if (st && !sp) begin m_run[d] = 1; m_cyc[d] = 0; end
         return;
      end
      m_cyc[d]++;
      if (m_cyc[d] < 5 && sp) m_pend[d] = 1;
      op  = m_word[d] >> m_w[d];
      imm = m_word[d] & mask;
      case (m_cyc[d])
         1: m_word[d] = m_mem[d][m_pc[d]];
         2: begin m_ocf[d] = m_cf[d]; m_ozf[d] = m_zf[d]; end
         3: m_in[d] = gin & mask;
         4: begin
            case (op)
               2, 5, 9: src = m_b[d];
               3, 4:    src = m_a[d];
               6, 7:    src = m_in[d];
               default: src = 0;
            endcase
            sum      = src + imm;
            m_cf[d]  = (sum > mask);
            m_res[d] = sum & mask;
            m_zf[d]  = (m_res[d] == 0);
         end
         default: begin
            case (op)
               0, 2, 4, 6: m_a[d]   = m_res[d];
               1, 3, 5, 7: m_b[d]   = m_res[d];
               8, 9:       m_out[d] = m_res[d];
               default: ;
            endcase
            taken = (op == 10) || (op == 11 && !m_ocf[d]) || (op == 13 && !m_ozf[d]);
            m_pc[d] = taken ? (m_res[d] & 15) : ((m_pc[d] + 1) & 15);
            if (sp || m_pend[d] || op == 12) m_run[d] = 0;
            m_pend[d] = 0;
            m_cyc[d]  = 0;
         end
      endcase
   endtask

   // Advance the model on the same edge the DUTs sample their inputs
   always @(posedge clock) begin
      model_step(0, reset_p, start, stop, prog_we, int'(prog_addr), int'(prog_data0), int'(gpio_in0));
      model_step(1, reset_p, start, stop, prog_we, int'(prog_addr), int'(prog_data1), int'(gpio_in1));
   end

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Every-cycle comparison of all outputs against the model
   always @(negedge clock) begin
      if (chk_en) begin
         check("halted4", int'(halted0),   int'(!m_run[0]));
         check("pc4",     int'(pc_out0),   m_pc[0]);
         check("gpio4",   int'(gpio_out0), m_out[0]);
         check("flags4",  int'(flags0),    int'({m_zf[0], m_cf[0]}));
         check("halted8", int'(halted1),   int'(!m_run[1]));
         check("pc8",     int'(pc_out1),   m_pc[1]);
         check("gpio8",   int'(gpio_out1), m_out[1]);
         check("flags8",  int'(flags1),    int'({m_zf[1], m_cf[1]}));
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic load(input int addr, input int d0, input int d1);
      @(negedge clock);
      prog_we = 1'b1; prog_addr = 4'(addr); prog_data0 = 8'(d0); prog_data1 = 12'(d1);
      @(negedge clock);
      prog_we = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clock); reset_p = 1'b1;
      @(negedge clock); reset_p = 1'b0;
   endtask

   task automatic pulse_start();
      @(negedge clock); start = 1'b1;
      @(negedge clock); start = 1'b0;
   endtask

   task automatic wait_halted(input int maxc);
      int n;
      n = 0;
      while (!(halted0 && halted1) && n < maxc) begin
         @(negedge clock);
         n++;
      end
      n_checks++;
      if (!(halted0 && halted1)) begin
         n_errors++;
         $display("FAIL wait_halted: got running expected halted within %0d cycles", maxc);
      end
   endtask

   initial begin
      reset_p = 1'b1; start = 1'b0; stop = 1'b0; prog_we = 1'b0;
      prog_addr = '0; prog_data0 = '0; prog_data1 = '0; gpio_in0 = '0; gpio_in1 = '0;
      repeat (2) @(negedge clock);
      reset_p = 1'b0;
      chk_en  = 1'b1;
      // Reset state pinned literally
      check("rst_halted", int'(halted0), 1);
      check("rst_pc",     int'(pc_out0), 0);
      check("rst_gpio",   int'(gpio_out1), 0);
      check("rst_flags",  int'(flags1), 0);

      // Fill both programs with HLT
      for (int a = 0; a < 16; a++) load(a, 8'hC0, 12'hC00);

      // 1: OUT 5; HLT
      load(0, 8'h85, 12'hC00);
      load(1, 8'hC0, 12'hC00);
      do_reset();
      pulse_start();
      repeat (4) @(negedge clock);
      check("t1_gpio_early", int'(gpio_out0), 0);
      @(negedge clock);
      check("t1_gpio", int'(gpio_out0), 5);
      check("t1_running", int'(halted0), 0);
      repeat (5) @(negedge clock);
      check("t1_halted", int'(halted0), 1);
      check("t1_pc", int'(pc_out0), 2);

      // 2: carry loop with JNC
      load(0, 8'h0E, 12'hC00); load(1, 8'h41, 12'hC00); load(2, 8'hB1, 12'hC00);
      load(3, 8'h8F, 12'hC00); load(4, 8'hC0, 12'hC00);
      do_reset();
      pulse_start();
      wait_halted(100);
      check("t2_gpio", int'(gpio_out0), 15);
      check("t2_pc", int'(pc_out0), 5);
      check("t2_flags", int'(flags0), 2);

      // 3: JNZ countdown on the 8-bit instance
      load(0, 8'hC0, 12'h003); load(1, 8'hC0, 12'h4FF); load(2, 8'hC0, 12'hD01);
      load(3, 8'hC0, 12'h8AA); load(4, 8'hC0, 12'hC00);
      do_reset();
      pulse_start();
      repeat (44) @(negedge clock);
      check("t3_running", int'(halted1), 0);
      @(negedge clock);
      check("t3_halted", int'(halted1), 1);
      check("t3_gpio", int'(gpio_out1), 8'hAA);
      check("t3_pc", int'(pc_out1), 5);

      // 4: stop during DECODE of instruction 1
      load(0, 8'h83, 12'hC00); load(1, 8'h84, 12'hC00); load(2, 8'h85, 12'hC00);
      load(3, 8'hC0, 12'hC00); load(4, 8'hC0, 12'hC00);
      do_reset();
      pulse_start();
      repeat (6) @(negedge clock);
      stop = 1'b1;
      @(negedge clock);
      stop = 1'b0;
      repeat (3) @(negedge clock);
      check("t4_halted", int'(halted0), 1);
      check("t4_pc", int'(pc_out0), 2);
      check("t4_gpio", int'(gpio_out0), 4);
      pulse_start();
      repeat (5) @(negedge clock);
      check("t4_resume_gpio", int'(gpio_out0), 5);
      wait_halted(50);
      check("t4_resume_pc", int'(pc_out0), 4);

      // 5: prog_we while running is ignored; reset mid-EXEC
      load(0, 8'h81, 12'hC00); load(1, 8'h82, 12'hC00); load(2, 8'hC0, 12'hC00);
      do_reset();
      pulse_start();
      repeat (2) @(negedge clock);
      prog_we = 1'b1; prog_addr = 4'd1; prog_data0 = 8'h8D; prog_data1 = 12'h8DD;
      @(negedge clock);
      prog_we = 1'b0;
      wait_halted(50);
      check("t5_gpio", int'(gpio_out0), 2);
      pulse_start();
      repeat (3) @(negedge clock);
      reset_p = 1'b1;
      @(negedge clock);
      reset_p = 1'b0;
      check("t5_rst_halted", int'(halted0), 1);
      check("t5_rst_gpio", int'(gpio_out0), 0);
      check("t5_rst_pc", int'(pc_out0), 0);
      pulse_start();
      wait_halted(50);
      check("t5_rerun_gpio", int'(gpio_out0), 2);
      check("t5_rerun_pc", int'(pc_out0), 3);

      // 6: gpio_in path; start+stop together keeps HALT
      gpio_in0 = 4'h9;
      load(0, 8'h71, 12'hC00); load(1, 8'h90, 12'hC00); load(2, 8'hC0, 12'hC00);
      do_reset();
      pulse_start();
      wait_halted(50);
      check("t6_gpio", int'(gpio_out0), 4'hA);
      @(negedge clock); start = 1'b1; stop = 1'b1;
      @(negedge clock); start = 1'b0; stop = 1'b0;
      repeat (2) @(negedge clock);
      check("t6_stay_halted", int'(halted0), 1);
      check("t6_stay_pc", int'(pc_out0), 3);

      // Randomized traffic, checked every cycle by the model
      for (int i = 0; i < 4000; i++) begin
         @(negedge clock);
         reset_p    = ($urandom_range(0, 299) == 0);
         start      = ($urandom_range(0, 7) == 0);
         stop       = ($urandom_range(0, 39) == 0);
         prog_we    = ($urandom_range(0, 3) == 0);
         prog_addr  = 4'($urandom);
         prog_data0 = 8'($urandom);
         prog_data1 = 12'($urandom);
         gpio_in0   = 4'($urandom);
         gpio_in1   = 8'($urandom);
      end
      @(negedge clock);
      reset_p = 1'b0; start = 1'b0; prog_we = 1'b0; stop = 1'b1;
      @(negedge clock);
      stop = 1'b0;
      wait_halted(20);
      @(negedge clock);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
